power_spectrum: RTL and testbench

Streaming power-spectrum stage that sits directly upstream of the mel filter bank. It accepts complex FFT bins one per handshake and computes |X|² = re² + im² for each bin. Only the first N_BINS bins (the non-redundant half-spectrum) are forwarded, as 32-bit unsigned words, on a valid/ready stream that matches the mel filter bank's `in`/`s_valid`/`s_ready` input. Bins above N_BINS are consumed and discarded, and frame-length violations are flagged.

---
 rtl/power_spectrum.sv | 96 +++++++++
 tb/tb_power_spectrum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/power_spectrum.sv
// power_spectrum: streaming |X|^2 stage forwarding the first N_BINS bins of each FFT frame.
// Optional build macro POWSPEC_DC_ZERO_EN forces the bin 0 power to zero.
module power_spectrum #(
  parameter int FFT_LEN = 512,
  parameter int N_BINS  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_re,
  input  logic [15:0] s_im,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_err
);

  localparam int BW = $clog2(FFT_LEN);
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_LEN - 1);
  localparam logic [BW-1:0] LAST_FWD = BW'(N_BINS - 1);
  localparam logic [BW-1:0] NUM_FWD  = BW'(N_BINS);

  logic          rdy_q;
  logic          adv;
  logic          hs;
  logic          end_bin;
  logic [BW-1:0] bin;

  logic signed [31:0] re_ext, im_ext;
  logic signed [31:0] prod_re, prod_im;
  logic [31:0]        sq_re, sq_im;
  logic               v1, l1;

  // The whole pipeline advances together; a stalled output freezes every stage.
  assign adv     = rdy_q & (~m_valid | m_ready);
  assign s_ready = adv;
  assign hs      = s_valid & adv;
  assign end_bin = (bin == LAST_BIN);

  assign re_ext  = {{16{s_re[15]}}, s_re};
  assign im_ext  = {{16{s_im[15]}}, s_im};
  assign prod_re = re_ext * re_ext;
  assign prod_im = im_ext * im_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      bin       <= '0;
      frame_err <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      // Short frame (early s_last) and long frame (missing s_last) both resync to bin 0.
      frame_err <= hs & (s_last ^ end_bin);
      if (hs) begin
        bin <= (s_last | end_bin) ? '0 : bin + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_re <= '0;
      sq_im <= '0;
      v1    <= 1'b0;
      l1    <= 1'b0;
    end else if (adv) begin
      sq_re <= prod_re;
      sq_im <= prod_im;
      v1    <= s_valid & (bin < NUM_FWD);
      l1    <= (bin == LAST_FWD);
`ifdef POWSPEC_DC_ZERO_EN
      if (bin == '0) begin
        sq_re <= '0;
        sq_im <= '0;
      end
`endif
    end
  end

  // Each square is at most 2^30, so the sum fits in 32 bits without saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (adv) begin
      m_data  <= sq_re + sq_im;
      m_valid <= v1;
      m_last  <= l1;
    end
  end

endmodule

// File: tb/tb_power_spectrum.sv
// Self-checking bench for power_spectrum: vector table, directed frame sequences and
// randomized traffic scored against a frame-level reference model.
module tb_power_spectrum;

  localparam int FFT_LEN = 512;
  localparam int N_BINS  = 256;
`ifdef POWSPEC_DC_ZERO_EN
  localparam logic [31:0] DC_EXP = 32'd0;
`else
  localparam logic [31:0] DC_EXP = 32'd20000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_re, s_im;
  logic        s_last, s_valid, s_ready;
  logic [31:0] m_data;
  logic        m_last, m_valid, m_ready;
  logic        frame_err;

  always #5 clk = ~clk;

  power_spectrum #(.FFT_LEN(FFT_LEN), .N_BINS(N_BINS)) dut (
    .clk(clk), .reset(reset), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .frame_err(frame_err)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_data_q[$];
  logic        exp_last_q[$];
  int   model_bin = 0;
  bit   err_prev = 0, stall_prev = 0, hs_seen = 0, rand_ready = 0, has_exp = 0;
  logic [31:0] held_data, cur_exp;
  logic        held_last;
  int   cyc = 0, rel_cyc = 0, err_count = 0, first_hs_cyc = -1, first_out_cyc = -1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: frame position tracked as a plain integer, power by integer arithmetic.
  task automatic model_accept();
    longint r = longint'($signed(s_re));
    longint i = longint'($signed(s_im));
    logic [31:0] p;
    if (model_bin < N_BINS) begin
      p = has_exp ? cur_exp : 32'(r * r + i * i);
`ifdef POWSPEC_DC_ZERO_EN
      if (model_bin == 0 && !has_exp) p = 32'd0;
`endif
      exp_data_q.push_back(p);
      exp_last_q.push_back(model_bin == N_BINS - 1);
    end
    if (s_last != (model_bin == FFT_LEN - 1)) err_prev = 1;
    model_bin = (s_last || model_bin == FFT_LEN - 1) ? 0 : model_bin + 1;
  endtask

  task automatic cycle();
    logic [31:0] d;
    logic        l;
    @(negedge clk);
    cyc++;
    check("frame_err", 32'(frame_err), 32'(err_prev));
    if (frame_err) err_count++;
    if (stall_prev) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", m_data, held_data);
      check("hold_last", 32'(m_last), 32'(held_last));
    end
    if (m_valid && !m_ready) check("stall_s_ready", 32'(s_ready), 32'd0);
    stall_prev = m_valid && !m_ready;
    held_data  = m_data;
    held_last  = m_last;
    if (m_valid && m_ready) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_data_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_output: got 0x%0h, want no output", m_data);
      end else begin
        d = exp_data_q.pop_front();
        l = exp_last_q.pop_front();
        $display("out cycle=%0d data=0x%08h last=%0b exp=0x%08h/%0b", cyc, m_data, m_last, d, l);
        check("m_data", m_data, d);
        check("m_last", 32'(m_last), 32'(l));
      end
    end
    err_prev = 0;
    hs_seen  = 0;
    if (s_valid && s_ready) begin
      hs_seen = 1;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      model_accept();
    end
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(logic [15:0] re, logic [15:0] im, logic last,
                      bit use_exp, logic [31:0] e, bit gap);
    int n = 0;
    if (gap) begin
      s_valid = 1'b0;
      cycle();
    end
    s_re = re; s_im = im; s_last = last; s_valid = 1'b1;
    has_exp = use_exp; cur_exp = e;
    do begin
      cycle();
      n++;
    end while (!hs_seen && n < 200);
    if (!hs_seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no handshake in %0d cycles, want one", n);
    end
    has_exp = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_data_q.delete();
    exp_last_q.delete();
    model_bin = 0; err_prev = 0; stall_prev = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", m_data, 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    int e0, start, n;
    tbl[0] = '{re: 16'd100,   im: 16'd100,   exp: DC_EXP};
    tbl[1] = '{re: 16'd100,   im: 16'd100,   exp: 32'd20000};
    tbl[2] = '{re: 16'd3,     im: 16'd4,     exp: 32'd25};
    tbl[3] = '{re: 16'h8000,  im: 16'h8000,  exp: 32'h8000_0000};
    tbl[4] = '{re: 16'd0,     im: 16'd0,     exp: 32'd0};
    tbl[5] = '{re: 16'hFFFF,  im: 16'd1,     exp: 32'd2};

    m_ready = 1'b1;
    s_valid = 1'b1; s_re = tbl[0].re; s_im = tbl[0].im; s_last = 1'b0;
    do_reset();

    // Frame 1: vector table, then random fill to a proper end of frame.
    for (int k = 0; k < 6; k++) send(tbl[k].re, tbl[k].im, 1'b0, 1'b1, tbl[k].exp, 1'b0);
    check("first_handshake_cycle", 32'(first_hs_cyc), 32'(rel_cyc + 2));
    check("first_output_latency", 32'(first_out_cyc - first_hs_cyc), 32'd2);
    for (int k = 6; k < FFT_LEN; k++)
      send(16'($urandom), 16'($urandom), k == FFT_LEN - 1, 1'b0, 32'd0, 1'b0);

    // Full ramp frame with no backpressure.
    for (int k = 0; k < FFT_LEN; k++)
      send(16'(k), 16'd0, k == FFT_LEN - 1, 1'b0, 32'd0, 1'b0);

    // Same ramp frame under random backpressure and random input gaps.
    rand_ready = 1;
    for (int k = 0; k < FFT_LEN; k++)
      send(16'(k), 16'd0, k == FFT_LEN - 1, 1'b0, 32'd0, $urandom_range(0, 7) == 0);
    rand_ready = 0;

    // Short frame, then long frame, then resync to a clean frame boundary.
    e0 = err_count;
    for (int k = 0; k <= 100; k++)
      send(16'($urandom), 16'($urandom), k == 100, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 520; k++)
      send(16'($urandom), 16'($urandom), 1'b0, 1'b0, 32'd0, 1'b0);
    start = model_bin;
    for (int k = start; k < FFT_LEN; k++)
      send(16'($urandom), 16'($urandom), k == FFT_LEN - 1, 1'b0, 32'd0, 1'b0);
    check("frame_err_pulses", 32'(err_count - e0), 32'd2);

    // Reset in the middle of a frame; the next accepted bin is bin 0.
    for (int k = 0; k < 40; k++)
      send(16'($urandom), 16'($urandom), 1'b0, 1'b0, 32'd0, 1'b0);
    do_reset();
    rand_ready = 1;
    for (int k = 0; k < FFT_LEN; k++)
      send(16'($urandom), 16'($urandom), k == FFT_LEN - 1, 1'b0, 32'd0, 1'b0);
    rand_ready = 0;

    s_valid = 1'b0;
    n = 0;
    while (exp_data_q.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(exp_data_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
